nnz_row_issuer: RTL

NNZ_ROW_ISSUER -- requirements
Module: nnz_row_issuer

---
 rtl/nnz_row_issuer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/nnz_row_issuer.sv
`timescale 1ns/1ps
// nnz_row_issuer
//   Streams CSR row pointers and issues one row per consecutive pointer pair,
//   together with a last-value prediction of that row's nonzero count. The
//   inspector's match result comes back FB_LAT cycles after each issue, and
//   every mismatch is counted.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   start             begins a pass (accepted in IDLE or DONE)
//   rp_data/valid/last row-pointer stream; rp_ready is high in PRIME and ISSUE
//   offset1/offset2   row_ptr[i+1] / row_ptr[i] of the issued row
//   pred_out          predicted nnz for the issued row
//   issue_valid       the three outputs above carry a row this cycle
//   match             inspector result, sampled FB_LAT cycles after each issue
//   row_cnt           rows issued this pass (saturating)
//   mispred_cnt       match=0 feedback results this pass (saturating)
//   busy, done        pass in progress / pass complete
module nnz_row_issuer #(
   parameter int unsigned FB_LAT = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      rp_data,
   input  logic             rp_valid,
   input  logic             rp_last,
   output logic             rp_ready,
   output logic [31:0]      offset1,
   output logic [31:0]      offset2,
   output logic [31:0]      pred_out,
   output logic             issue_valid,
   input  logic             match,
   output logic [CNT_W-1:0] row_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StPrime = 3'd1;
   localparam logic [2:0] StIssue = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [2:0]        state_q, state_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       prev_nnz_q, prev_nnz_d;
   logic [31:0]       offset1_q, offset1_d;
   logic [31:0]       offset2_q, offset2_d;
   logic [31:0]       pred_q, pred_d;
   logic              issue_valid_q, issue_valid_d;
   // Bit i set: an issue happened i+1 cycles ago; the tail bit marks the
   // cycle whose match input belongs to a real row.
   logic [FB_LAT-1:0] track_q, track_d;
   logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
   logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      state_d       = state_q;
      lo_d          = lo_q;
      prev_nnz_d    = prev_nnz_q;
      offset1_d     = offset1_q;
      offset2_d     = offset2_q;
      pred_d        = pred_q;
      issue_valid_d = 1'b0;
      row_cnt_d     = row_cnt_q;
      mispred_cnt_d = mispred_cnt_q;

      track_d    = track_q;
      track_d[0] = issue_valid_q;
      for (int unsigned i = 1; i < FB_LAT; i++) begin
         track_d[i] = track_q[i-1];
      end

      if (track_q[FB_LAT-1] && !match && (mispred_cnt_q != CntMax)) begin
         mispred_cnt_d = mispred_cnt_q + 1'b1;
      end

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d       = StPrime;
               row_cnt_d     = '0;
               mispred_cnt_d = '0;
               prev_nnz_d    = '0;
            end
         end
         StPrime: begin
            if (rp_valid) begin
               lo_d    = rp_data;
               // A lone pointer describes an empty matrix: nothing to issue.
               state_d = rp_last ? StDrain : StIssue;
            end
         end
         StIssue: begin
            if (rp_valid) begin
               issue_valid_d = 1'b1;
               offset1_d     = rp_data;
               offset2_d     = lo_q;
               pred_d        = prev_nnz_q;
               lo_d          = rp_data;
               prev_nnz_d    = rp_data - lo_q;
               if (row_cnt_q != CntMax) begin
                  row_cnt_d = row_cnt_q + 1'b1;
               end
               if (rp_last) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // issue_valid_q is the stage feeding the tracker, so it must be
            // empty too before the last feedback can be considered counted.
            if ((track_q == '0) && !issue_valid_q) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         lo_q          <= '0;
         prev_nnz_q    <= '0;
         offset1_q     <= '0;
         offset2_q     <= '0;
         pred_q        <= '0;
         issue_valid_q <= 1'b0;
         track_q       <= '0;
         row_cnt_q     <= '0;
         mispred_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         lo_q          <= lo_d;
         prev_nnz_q    <= prev_nnz_d;
         offset1_q     <= offset1_d;
         offset2_q     <= offset2_d;
         pred_q        <= pred_d;
         issue_valid_q <= issue_valid_d;
         track_q       <= track_d;
         row_cnt_q     <= row_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign rp_ready    = (state_q == StPrime) || (state_q == StIssue);
   assign busy        = (state_q == StPrime) || (state_q == StIssue) || (state_q == StDrain);
   assign done        = (state_q == StDone);
   assign offset1     = offset1_q;
   assign offset2     = offset2_q;
   assign pred_out    = pred_q;
   assign issue_valid = issue_valid_q;
   assign row_cnt     = row_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
